// File: rtl/pc_branch_ctrl_if.sv
// Fetch-side bus between the branch/PC controller and the pipeline.
// The pipeline drives the branch resolution, stall and halt inputs; the
// controller returns the fetch address and the flush/taken/halt status.
interface pc_branch_ctrl_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) ();
    logic              stall_i;
    logic              br_valid_i;
    logic [1:0]        br_type_i;
    logic [PC_W-1:0]   br_npc_i;
    logic [IMM_W-1:0]  br_imm_i;
    logic [DATA_W-1:0] br_rs_i;
    logic              halt_i;

    logic [PC_W-1:0]   pc_o;
    logic [PC_W-1:0]   npc_o;
    logic              fetch_valid_o;
    logic              taken_o;
    logic              flush_o;
    logic              halted_o;

    // Pipeline side: drives requests, observes fetch status
    modport master (
        output stall_i, br_valid_i, br_type_i, br_npc_i, br_imm_i, br_rs_i, halt_i,
        input  pc_o, npc_o, fetch_valid_o, taken_o, flush_o, halted_o
    );

    // Controller side
    modport slave (
        input  stall_i, br_valid_i, br_type_i, br_npc_i, br_imm_i, br_rs_i, halt_i,
        output pc_o, npc_o, fetch_valid_o, taken_o, flush_o, halted_o
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// Program counter and branch controller.
// Resolves EX-stage branches, redirects the fetch PC, inserts a fixed number
// of bubble (flush) cycles after each taken branch and parks in HALT once a
// HLT instruction retires. All status outputs are registered.
module pc_branch_ctrl #(
    parameter int              PC_W        = 32,
    parameter int              DATA_W      = 32,
    parameter int              IMM_W       = 16,
    parameter int              FLUSH_SLOTS = 2,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic               clk1,
    input  logic               rst,
    pc_branch_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS);

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [2:0]      cnt_reg;
    logic            taken_reg;
    logic            flush_reg;
    logic            fetch_valid_reg;
    logic            halted_reg;

    logic            cond;
    logic            br_take;
    logic [PC_W-1:0] imm_pc;
    logic [PC_W-1:0] target;

    // Only the low PC_W bits of the offset matter for a modulo-2^PC_W sum,
    // so a wide offset is truncated and a narrow one is sign-extended.
    generate
        if (IMM_W >= PC_W) begin : g_imm_trunc
            assign imm_pc = bus.br_imm_i[PC_W-1:0];
        end else begin : g_imm_sext
            assign imm_pc = {{(PC_W-IMM_W){bus.br_imm_i[IMM_W-1]}}, bus.br_imm_i};
        end
    endgenerate

    assign target = bus.br_npc_i + imm_pc;

    // Branch condition decode; the reserved type is never taken
    always_comb begin
        cond = 1'b0;
        unique case (bus.br_type_i)
            2'b00:   cond = (bus.br_rs_i == '0);
            2'b01:   cond = (bus.br_rs_i != '0);
            2'b10:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign br_take = bus.br_valid_i && cond;

    // Control FSM: PC update, flush countdown, halt, registered status outputs
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC;
            cnt_reg         <= 3'd0;
            taken_reg       <= 1'b0;
            flush_reg       <= 1'b0;
            fetch_valid_reg <= 1'b1;
            halted_reg      <= 1'b0;
        end else begin
            // taken is a single-cycle pulse unless re-armed below
            taken_reg <= 1'b0;
            unique case (state_reg)
                RUN: begin
                    if (bus.halt_i) begin
                        // halt wins over a simultaneous taken branch
                        state_reg       <= HALT;
                        cnt_reg         <= 3'd0;
                        flush_reg       <= 1'b0;
                        fetch_valid_reg <= 1'b0;
                        halted_reg      <= 1'b1;
                    end else if (!bus.stall_i) begin
                        if (br_take) begin
                            pc_reg    <= target;
                            taken_reg <= 1'b1;
                            if (FLUSH_SLOTS > 0) begin
                                state_reg       <= FLUSH;
                                cnt_reg         <= FLUSH_INIT;
                                flush_reg       <= 1'b1;
                                fetch_valid_reg <= 1'b0;
                            end
                        end else begin
                            pc_reg <= pc_reg + PC_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    // branches seen here are on the wrong path and ignored
                    if (bus.halt_i) begin
                        state_reg       <= HALT;
                        cnt_reg         <= 3'd0;
                        flush_reg       <= 1'b0;
                        fetch_valid_reg <= 1'b0;
                        halted_reg      <= 1'b1;
                    end else if (!bus.stall_i) begin
                        if (cnt_reg == 3'd1) begin
                            state_reg       <= RUN;
                            cnt_reg         <= 3'd0;
                            flush_reg       <= 1'b0;
                            fetch_valid_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 3'd1;
                        end
                    end
                end
                HALT: begin
                    // parked until reset
                end
                default: begin
                    state_reg       <= RUN;
                    cnt_reg         <= 3'd0;
                    flush_reg       <= 1'b0;
                    fetch_valid_reg <= 1'b1;
                    halted_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_o          = pc_reg;
    assign bus.npc_o         = pc_reg + PC_W'(1);
    assign bus.fetch_valid_o = fetch_valid_reg;
    assign bus.taken_o       = taken_reg;
    assign bus.flush_o       = flush_reg;
    assign bus.halted_o      = halted_reg;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Bench for pc_branch_ctrl: directed stimulus, a per-cycle reference model
// and hand-computed literal checks on the key scenarios.
module tb_pc_branch_ctrl;

    localparam int PC_W   = 8;
    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int FS     = 2;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    int tests = 0;
    int fails = 0;

    always #5 clk1 = ~clk1;

    pc_branch_ctrl_if #(.PC_W(PC_W), .DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();

    pc_branch_ctrl #(
        .PC_W(PC_W), .DATA_W(DATA_W), .IMM_W(IMM_W),
        .FLUSH_SLOTS(FS), .RESET_PC(8'd0)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_left = bubble cycles still to come before the target is fetched validly
    int m_pc     = 0;
    int m_left   = 0;
    bit m_halted = 0;
    bit m_taken  = 0;

    function automatic bit br_cond(input logic [1:0] t, input logic [DATA_W-1:0] rs);
        case (t)
            2'b00:   return rs == 0;
            2'b01:   return rs != 0;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk1 or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_left = 0; m_halted = 0; m_taken = 0;
        end else begin
            m_taken = 0;
            if (m_halted) begin
                // frozen
            end else if (bus.halt_i) begin
                m_halted = 1;
                m_left   = 0;
            end else if (bus.stall_i) begin
                // nothing moves
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (bus.br_valid_i && br_cond(bus.br_type_i, bus.br_rs_i)) begin
                m_pc    = (((int'(bus.br_npc_i) + int'($signed(bus.br_imm_i))) % 256) + 256) % 256;
                m_left  = FS;
                m_taken = 1;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk1) begin
        if (!rst) begin
            chk("m_pc",     int'(bus.pc_o),          m_pc);
            chk("m_npc",    int'(bus.npc_o),         (m_pc + 1) % 256);
            chk("m_fvalid", int'(bus.fetch_valid_o), int'(!m_halted && m_left == 0));
            chk("m_flush",  int'(bus.flush_o),       int'(!m_halted && m_left > 0));
            chk("m_halted", int'(bus.halted_o),      int'(m_halted));
            chk("m_taken",  int'(bus.taken_o),       int'(m_taken));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk1);
        #2;
    endtask

    task automatic set_br(input logic v, input logic [1:0] t, input int rs,
                          input int npc, input int imm);
        bus.br_valid_i = v;
        bus.br_type_i  = t;
        bus.br_rs_i    = DATA_W'(rs);
        bus.br_npc_i   = PC_W'(npc);
        bus.br_imm_i   = IMM_W'(imm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_pc",     int'(bus.pc_o),          0);
        chk("rst_fvalid", int'(bus.fetch_valid_o), 1);
        chk("rst_flush",  int'(bus.flush_o),       0);
        chk("rst_taken",  int'(bus.taken_o),       0);
        chk("rst_halted", int'(bus.halted_o),      0);
        @(negedge clk1);
        #1 rst = 1'b0;
    endtask

    int nflush;

    initial begin
        bus.stall_i = 1'b0;
        bus.halt_i  = 1'b0;
        set_br(1'b0, 2'b00, 0, 0, 0);
        repeat (2) @(posedge clk1);
        do_reset();

        // Free run: 0,1,2,3,4
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("run_pc", int'(bus.pc_o), i);
            chk("run_taken", int'(bus.taken_o), 0);
        end

        // Taken BEQZ: 5 + 9 = 14, two bubbles, then 14 valid, then 15
        set_br(1'b1, 2'b00, 0, 5, 9);
        cyc();
        set_br(1'b0, 2'b00, 0, 0, 0);
        chk("beqz_pc", int'(bus.pc_o), 14);
        chk("beqz_taken", int'(bus.taken_o), 1);
        chk("beqz_flush1", int'(bus.flush_o), 1);
        cyc();
        chk("beqz_taken_drop", int'(bus.taken_o), 0);
        chk("beqz_flush2", int'(bus.flush_o), 1);
        cyc();
        chk("beqz_flush_end", int'(bus.flush_o), 0);
        chk("beqz_fetch14", int'(bus.pc_o), 14);
        chk("beqz_fvalid", int'(bus.fetch_valid_o), 1);
        cyc();
        chk("beqz_pc15", int'(bus.pc_o), 15);

        // BNEQZ with rs=0: not taken
        set_br(1'b1, 2'b01, 0, 5, 9);
        cyc();
        set_br(1'b0, 2'b00, 0, 0, 0);
        chk("bneqz_pc", int'(bus.pc_o), 16);
        chk("bneqz_flush", int'(bus.flush_o), 0);

        // Jump with negative offset wraps: 2 - 3 = 255
        set_br(1'b1, 2'b10, 0, 2, -3);
        cyc();
        set_br(1'b0, 2'b00, 0, 0, 0);
        chk("jmp_pc", int'(bus.pc_o), 255);
        chk("jmp_taken", int'(bus.taken_o), 1);
        repeat (2) cyc();
        chk("jmp_npc_wrap", int'(bus.npc_o), 0);
        cyc();
        chk("jmp_pc_wrap", int'(bus.pc_o), 0);

        // Stall 3 cycles inside FLUSH with a wrong-path jump presented
        set_br(1'b1, 2'b10, 0, 10, 0);
        cyc();
        nflush = int'(bus.flush_o);
        bus.stall_i = 1'b1;
        set_br(1'b1, 2'b10, 0, 100, 0);
        repeat (3) begin
            cyc();
            nflush += int'(bus.flush_o);
        end
        bus.stall_i = 1'b0;
        cyc();
        nflush += int'(bus.flush_o);
        set_br(1'b0, 2'b00, 0, 0, 0);
        cyc();
        chk("stall_flush_cycles", nflush, 5);
        chk("stall_pc", int'(bus.pc_o), 10);
        chk("stall_fvalid", int'(bus.fetch_valid_o), 1);

        // Branch presented while stalled in RUN is dropped
        bus.stall_i = 1'b1;
        set_br(1'b1, 2'b10, 0, 50, 0);
        cyc();
        chk("stall_br_pc", int'(bus.pc_o), 10);
        chk("stall_br_taken", int'(bus.taken_o), 0);
        bus.stall_i = 1'b0;
        set_br(1'b0, 2'b00, 0, 0, 0);
        cyc();
        chk("unstall_pc", int'(bus.pc_o), 11);

        // Reserved type never taken
        set_br(1'b1, 2'b11, 0, 40, 0);
        cyc();
        set_br(1'b0, 2'b00, 0, 0, 0);
        chk("rsvd_pc", int'(bus.pc_o), 12);
        chk("rsvd_taken", int'(bus.taken_o), 0);

        // Halt beats a simultaneous taken BEQZ
        bus.halt_i = 1'b1;
        set_br(1'b1, 2'b00, 0, 5, 9);
        cyc();
        bus.halt_i = 1'b0;
        set_br(1'b0, 2'b00, 0, 0, 0);
        chk("halt_pc", int'(bus.pc_o), 12);
        chk("halt_halted", int'(bus.halted_o), 1);
        chk("halt_taken", int'(bus.taken_o), 0);
        chk("halt_fvalid", int'(bus.fetch_valid_o), 0);
        repeat (2) cyc();
        chk("halt_sticky_pc", int'(bus.pc_o), 12);
        chk("halt_sticky", int'(bus.halted_o), 1);
        do_reset();

        // Halt during a stalled FLUSH
        repeat (2) cyc();
        set_br(1'b1, 2'b10, 0, 30, 0);
        cyc();
        set_br(1'b0, 2'b00, 0, 0, 0);
        bus.stall_i = 1'b1;
        bus.halt_i  = 1'b1;
        cyc();
        bus.stall_i = 1'b0;
        bus.halt_i  = 1'b0;
        chk("halt_flush_halted", int'(bus.halted_o), 1);
        chk("halt_flush_flush", int'(bus.flush_o), 0);
        chk("halt_flush_pc", int'(bus.pc_o), 30);
        do_reset();

        // Reset right after a taking edge: no residual taken/flush
        cyc();
        set_br(1'b1, 2'b10, 0, 60, 0);
        cyc();
        set_br(1'b0, 2'b00, 0, 0, 0);
        chk("pre_rst_taken", int'(bus.taken_o), 1);
        do_reset();
        repeat (3) cyc();
        chk("post_rst_pc", int'(bus.pc_o), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
